// File: rtl/saber_pkg.sv
// Shared state encodings and Power-block control codes for the saber sequencer.
package saber_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_IGNITE   = 3'd1,
    ST_ON       = 3'd2,
    ST_CLASH    = 3'd3,
    ST_RETRACT  = 3'd4,
    ST_DEPLETED = 3'd5
  } saber_state_e;

  localparam logic [1:0] USE_NONE   = 2'd0;
  localparam logic [1:0] USE_IDLE   = 2'd1;
  localparam logic [1:0] USE_IGNITE = 2'd2;
  localparam logic [1:0] USE_CLASH  = 2'd3;

  localparam logic MODE_DRAIN  = 1'b0;
  localparam logic MODE_CHARGE = 1'b1;

  function automatic logic [1:0] use_of(input saber_state_e s);
    logic [1:0] u;
    case (s)
      ST_IGNITE:  u = USE_IGNITE;
      ST_ON:      u = USE_IDLE;
      ST_CLASH:   u = USE_CLASH;
      ST_RETRACT: u = USE_IDLE;
      default:    u = USE_NONE;
    endcase
    return u;
  endfunction

  // Only the blade-down states let the Power block recharge.
  function automatic logic mode_of(input saber_state_e s);
    logic m;
    case (s)
      ST_IGNITE, ST_ON, ST_CLASH, ST_RETRACT: m = MODE_DRAIN;
      default:                                m = MODE_CHARGE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; the reset value of the history bit is a parameter
// so a level held high through reset is not reported as an edge.
module rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (rst) din_q <= RESET_VAL;
    else     din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/saber_sequencer.sv
// Lightsaber top-level sequencer: ignition, idle, clash, retraction and low-charge lockout,
// driving the Power, blade-config and color blocks of the saber datapath.
module saber_sequencer
  import saber_pkg::*;
#(
  parameter int unsigned IGNITE_STEPS = 8,
  parameter int unsigned LOW_POWER    = 16,
  parameter int unsigned CLASH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_btn,
  input  logic       clash,
  input  logic       cfg_req,
  input  logic [1:0] cfg_in,
  input  logic       color_req,
  input  logic [7:0] power_level,
  output logic [1:0] power_use,
  output logic       power_mode,
  output logic [1:0] config_set,
  output logic       cfg_ack,
  output logic       color_load,
  output logic [3:0] blade_len,
  output logic       saber_on,
  output logic [2:0] state
);

  localparam logic [3:0] STEPS      = 4'(IGNITE_STEPS);
  localparam logic [3:0] CLASH_LOAD = 4'(CLASH_CYCLES);
  localparam logic [8:0] LOW_LIM    = 9'(LOW_POWER);
  localparam logic [8:0] EXIT_LIM   = 9'(2 * LOW_POWER);

  saber_state_e state_q, state_d;
  logic [3:0]   len_d;
  logic [3:0]   clash_cnt, cnt_d;
  logic         dep_flag, dep_d;
  logic [1:0]   cfg_d;
  logic         ack_d, load_d;
  logic         btn_edge;
  logic         low;

  rise_detect #(.RESET_VAL(1'b1)) u_btn_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (pwr_btn),
    .rise (btn_edge)
  );

  assign low = ({1'b0, power_level} <= LOW_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_OFF;
      blade_len  <= 4'd0;
      clash_cnt  <= 4'd0;
      dep_flag   <= 1'b0;
      config_set <= 2'd0;
      cfg_ack    <= 1'b0;
      color_load <= 1'b0;
    end else begin
      state_q    <= state_d;
      blade_len  <= len_d;
      clash_cnt  <= cnt_d;
      dep_flag   <= dep_d;
      config_set <= cfg_d;
      cfg_ack    <= ack_d;
      color_load <= load_d;
    end
  end

  // Request/acknowledge: cfg_req and color_req are levels sampled on each edge while ON;
  // every sampled request yields a one-cycle cfg_ack / color_load on that same edge,
  // so a held request is acknowledged again every cycle. No back-pressure exists.
  always_comb begin
    state_d = state_q;
    len_d   = blade_len;
    cnt_d   = clash_cnt;
    dep_d   = dep_flag;
    cfg_d   = config_set;
    ack_d   = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (btn_edge && !low) state_d = ST_IGNITE;
      end
      ST_IGNITE: begin
        if (btn_edge || low) begin
          state_d = ST_RETRACT;
        end else begin
          len_d = blade_len + 4'd1;
          if (blade_len == STEPS - 4'd1) state_d = ST_ON;
        end
      end
      ST_ON, ST_CLASH: begin
        if (low) begin
          state_d = ST_RETRACT;
          dep_d   = 1'b1;
        end else if (btn_edge) begin
          state_d = ST_RETRACT;
        end else if (clash) begin
          state_d = ST_CLASH;
          cnt_d   = CLASH_LOAD;
        end else if (state_q == ST_ON) begin
          if (cfg_req) begin
            cfg_d = cfg_in;
            ack_d = 1'b1;
          end
          load_d = color_req;
        end else if (clash_cnt <= 4'd1) begin
          state_d = ST_ON;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = clash_cnt - 4'd1;
        end
      end
      ST_RETRACT: begin
        // A low reading on the final retract edge still routes the blade into lockout.
        if (blade_len <= 4'd1) begin
          len_d   = 4'd0;
          state_d = (dep_flag || low) ? ST_DEPLETED : ST_OFF;
        end else begin
          len_d = blade_len - 4'd1;
        end
        if (low) dep_d = 1'b1;
      end
      ST_DEPLETED: begin
        if ({1'b0, power_level} >= EXIT_LIM) begin
          state_d = ST_OFF;
          dep_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign power_use  = use_of(state_q);
  assign power_mode = mode_of(state_q);
  assign saber_on   = (state_q == ST_ON) || (state_q == ST_CLASH);
  assign state      = state_q;

endmodule

// File: tb/tb_saber_sequencer.sv
// Self-checking bench for saber_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the saber's rules.
module tb_saber_sequencer;

  localparam int IGNITE_STEPS = 8;
  localparam int LOW_POWER    = 16;
  localparam int CLASH_CYCLES = 4;

  // clock / reset / DUT signals
  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_btn;
  logic       clash;
  logic       cfg_req;
  logic [1:0] cfg_in;
  logic       color_req;
  logic [7:0] power_level;
  logic [1:0] power_use;
  logic       power_mode;
  logic [1:0] config_set;
  logic       cfg_ack;
  logic       color_load;
  logic [3:0] blade_len;
  logic       saber_on;
  logic [2:0] state;

  always #5 clk = ~clk;

  saber_sequencer #(
    .IGNITE_STEPS(IGNITE_STEPS),
    .LOW_POWER   (LOW_POWER),
    .CLASH_CYCLES(CLASH_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwr_btn    (pwr_btn),
    .clash      (clash),
    .cfg_req    (cfg_req),
    .cfg_in     (cfg_in),
    .color_req  (color_req),
    .power_level(power_level),
    .power_use  (power_use),
    .power_mode (power_mode),
    .config_set (config_set),
    .cfg_ack    (cfg_ack),
    .color_load (color_load),
    .blade_len  (blade_len),
    .saber_on   (saber_on),
    .state      (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: state as an integer phase, blade length, remaining clash time.
  localparam int P_OFF = 0, P_IGN = 1, P_ON = 2, P_CLASH = 3, P_RET = 4, P_DEP = 5;
  int use_tab [6] = '{0, 2, 1, 3, 1, 0};
  int mode_tab[6] = '{1, 0, 0, 0, 0, 1};

  int m_state, m_len, m_clash_left, m_cfg, m_ack, m_load;
  bit m_dep, m_btn_q;

  logic [14:0] exp_q[$];

  task automatic model_step();
    bit edge_now, low_now;
    edge_now = pwr_btn && !m_btn_q;
    low_now  = (int'(power_level) <= LOW_POWER);
    m_ack  = 0;
    m_load = 0;
    if (rst) begin
      m_state = P_OFF; m_len = 0; m_clash_left = 0; m_cfg = 0; m_dep = 0; m_btn_q = 1;
      return;
    end
    m_btn_q = pwr_btn;
    case (m_state)
      P_OFF: if (edge_now && !low_now) m_state = P_IGN;
      P_IGN: begin
        if (edge_now || low_now) m_state = P_RET;
        else begin
          m_len = m_len + 1;
          if (m_len == IGNITE_STEPS) m_state = P_ON;
        end
      end
      P_ON, P_CLASH: begin
        if (low_now) begin m_state = P_RET; m_dep = 1; end
        else if (edge_now) m_state = P_RET;
        else if (clash) begin m_state = P_CLASH; m_clash_left = CLASH_CYCLES; end
        else if (m_state == P_ON) begin
          if (cfg_req) begin m_cfg = int'(cfg_in); m_ack = 1; end
          if (color_req) m_load = 1;
        end else begin
          m_clash_left = m_clash_left - 1;
          if (m_clash_left == 0) m_state = P_ON;
        end
      end
      P_RET: begin
        if (low_now) m_dep = 1;
        if (m_len > 0) m_len = m_len - 1;
        if (m_len == 0) m_state = m_dep ? P_DEP : P_OFF;
      end
      P_DEP: if (int'(power_level) >= 2 * LOW_POWER) begin m_state = P_OFF; m_dep = 0; end
      default: m_state = P_OFF;
    endcase
  endtask

  function automatic logic [14:0] pack_exp();
    logic on_e;
    on_e = (m_state == P_ON) || (m_state == P_CLASH);
    return {3'(m_state), 4'(m_len), 2'(use_tab[m_state]), 1'(mode_tab[m_state]),
            2'(m_cfg), 1'(m_ack), 1'(m_load), on_e};
  endfunction

  task automatic compare_outputs();
    logic [14:0] e;
    e = exp_q.pop_front();
    check("state",      state,      e[14:12]);
    check("blade_len",  blade_len,  e[11:8]);
    check("power_use",  power_use,  e[7:6]);
    check("power_mode", power_mode, e[5]);
    check("config_set", config_set, e[4:3]);
    check("cfg_ack",    cfg_ack,    e[2]);
    check("color_load", color_load, e[1]);
    check("saber_on",   saber_on,   e[0]);
  endtask

  // driver: inputs already applied; advance one edge and score the result
  task automatic cycle();
    model_step();
    exp_q.push_back(pack_exp());
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic wait_state(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(state) != target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, state, target);
  endtask

  task automatic press();
    pwr_btn = 1'b0;
    cycle();
    pwr_btn = 1'b1;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; pwr_btn = 1'b1; clash = 1'b0; cfg_req = 1'b0; cfg_in = 2'd0;
    color_req = 1'b0; power_level = 8'd200;
    m_state = P_OFF; m_len = 0; m_clash_left = 0; m_cfg = 0; m_dep = 0; m_btn_q = 1;
    m_ack = 0; m_load = 0;

    // reset with the button held: no ignition afterwards
    repeat (3) cycle();
    rst = 1'b0;
    repeat (3) cycle();
    check("held_btn_off", state, P_OFF);

    // ignition: length 1..IGNITE_STEPS, then ON
    press();
    check("ign_enter", state, P_IGN);
    for (int k = 1; k <= IGNITE_STEPS; k++) begin
      cycle();
      check("ign_len", blade_len, k);
    end
    check("ign_on", state, P_ON);
    check("ign_use", power_use, 1);
    check("ign_saber_on", saber_on, 1);

    // single clash lasts CLASH_CYCLES
    clash = 1'b1; cycle(); clash = 1'b0;
    n = (power_use == 2'd3) ? 1 : 0;
    repeat (8) begin cycle(); if (power_use == 2'd3) n++; end
    check("clash_len", n, CLASH_CYCLES);
    check("clash_back_on", power_use, 1);

    // reload on the third CLASH edge extends to 6 cycles
    n = 0;
    clash = 1'b1; cycle(); if (power_use == 2'd3) n++;
    clash = 1'b0; cycle(); if (power_use == 2'd3) n++;
    clash = 1'b1; cycle(); if (power_use == 2'd3) n++;
    clash = 1'b0;
    repeat (10) begin cycle(); if (power_use == 2'd3) n++; end
    check("clash_ext", n, 6);

    // config and color served together
    cfg_req = 1'b1; cfg_in = 2'd3; color_req = 1'b1;
    cycle();
    check("cfg_set", config_set, 3);
    check("cfg_ack_hi", cfg_ack, 1);
    check("color_hi", color_load, 1);
    cfg_req = 1'b0; color_req = 1'b0; cfg_in = 2'd0;
    cycle();
    check("cfg_ack_lo", cfg_ack, 0);
    check("color_lo", color_load, 0);
    check("cfg_hold", config_set, 3);

    // retract to OFF, then abort an ignition at length 5
    press();
    wait_state(P_OFF, 20, "ret_off");
    press();
    pwr_btn = 1'b0;
    repeat (5) cycle();
    check("abort_len5", blade_len, 5);
    pwr_btn = 1'b1;
    cycle();
    check("abort_ret", state, P_RET);
    check("abort_ret_len", blade_len, 5);
    for (int k = 4; k >= 0; k--) begin
      cycle();
      check("abort_len", blade_len, k);
    end
    check("abort_off", state, P_OFF);
    check("abort_mode", power_mode, 1);

    // low charge in ON: retract, lockout, hysteresis exit
    press();
    wait_state(P_ON, 20, "dep_reach_on");
    power_level = 8'd16;
    cycle();
    check("dep_ret", state, P_RET);
    wait_state(P_DEP, 20, "dep_enter");
    press();
    press();
    check("dep_btn_ignored", state, P_DEP);
    power_level = 8'd31;
    repeat (3) cycle();
    check("dep_stay31", state, P_DEP);
    power_level = 8'd32;
    cycle();
    check("dep_exit32", state, P_OFF);

    // reset in CLASH with the blade fully extended
    power_level = 8'd200;
    press();
    wait_state(P_ON, 20, "rst_reach_on");
    clash = 1'b1; cycle(); clash = 1'b0;
    check("rst_in_clash", state, P_CLASH);
    check("rst_len8", blade_len, IGNITE_STEPS);
    rst = 1'b1;
    cycle();
    check("rst_state", state, P_OFF);
    check("rst_len", blade_len, 0);
    check("rst_use", power_use, 0);
    check("rst_mode", power_mode, 1);
    check("rst_cfg", config_set, 0);
    check("rst_on", saber_on, 0);
    rst = 1'b0;

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) pwr_btn = ~pwr_btn;
      clash     = ($urandom_range(0, 15) == 0);
      cfg_req   = ($urandom_range(0, 3) == 0);
      cfg_in    = 2'($urandom_range(0, 3));
      color_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0)      power_level = 8'($urandom_range(0, 40));
      else if ($urandom_range(0, 9) == 0)  power_level = 8'($urandom_range(41, 255));
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/saber_sequencer.md
# saber_sequencer

Top-level lightsaber controller that sequences ignition, idle, clash and retraction of the blade, and drives the power, blade-configuration and color-load controls of the existing saber datapath. It sits between user inputs (power button, clash sensor, config requests) and the Power, blade-config and color blocks. It reads the Power block's remaining charge and forces a retract and lockout when charge runs low.

## Interface
Parameters:
- IGNITE_STEPS, 8: blade extension/retraction steps; range 1..15.
- LOW_POWER, 16: charge at or below this forces shutdown; exit from lockout at 2*LOW_POWER.
- CLASH_CYCLES, 4: cycles of heavy drain per clash event; range 1..15.

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- pwr_btn  in  1  power button level; rising edge toggles ignite/retract.
- clash  in  1  clash sensor; sampled as a level.
- cfg_req  in  1  blade-config change request.
- cfg_in  in  2  requested blade configuration.
- color_req  in  1  color change request.
- power_level  in  8  remaining charge from the Power block, unsigned.
- power_use  out  2  drain rate to Power: 0 none, 1 idle, 2 ignite, 3 clash.
- power_mode  out  1  0 = drain, 1 = charge.
- config_set  out  2  blade configuration to the config register.
- cfg_ack  out  1  one-cycle pulse when a config request is accepted.
- color_load  out  1  one-cycle load strobe to the color registers.
- blade_len  out  4  current blade extension, 0..IGNITE_STEPS.
- saber_on  out  1  high in ON and CLASH.
- state  out  3  current FSM state, for debug.

## Operation
- States and encodings: OFF=0, IGNITE=1, ON=2, CLASH=3, RETRACT=4, DEPLETED=5. Encodings 6–7 go to OFF on the next edge.
- Button edge: `btn_edge = pwr_btn & ~btn_q`, where `btn_q` is `pwr_btn` registered.
- Low-power flag: `low = (power_level <= LOW_POWER)`.
- OFF: power_use=0, power_mode=1. If `btn_edge & ~low`, go to IGNITE. If `btn_edge & low`, ignore.
- IGNITE: power_use=2, power_mode=0. `blade_len` increments each cycle.
  - Go to ON on the edge where `blade_len` becomes IGNITE_STEPS.
  - If `btn_edge` or `low`, go to RETRACT, starting from the current length.
- ON: power_use=1, power_mode=0. Priority, highest first:
  - `low`: go to RETRACT and set `dep_flag`.
  - `btn_edge`: go to RETRACT.
  - `clash`: go to CLASH, load the clash counter with CLASH_CYCLES.
  - `cfg_req`: `config_set <= cfg_in`, pulse `cfg_ack`.
  - `color_req`: pulse `color_load`.
  - `cfg_req` and `color_req` in the same cycle are both served.
- CLASH: power_use=3, power_mode=0. Counter decrements each cycle; return to ON when it reaches 0.
  - `low` and `btn_edge` behave as in ON.
  - Further `clash` reloads the counter.
  - Config and color requests are ignored.
- RETRACT: power_use=1, power_mode=0. `blade_len` decrements each cycle.
  - At 0, go to DEPLETED if `dep_flag`, else OFF.
  - Button is ignored. A low-power condition during RETRACT sets `dep_flag`.
- DEPLETED: power_use=0, power_mode=1. Button is ignored. Go to OFF and clear `dep_flag` when `power_level >= 2*LOW_POWER`.
- power_use, power_mode and saber_on are Moore decodes of the state register. blade_len, config_set, cfg_ack and color_load are registers.

## Timing
- Reset values: state=OFF, blade_len=0, power_use=0, power_mode=1, config_set=0, cfg_ack=0, color_load=0, saber_on=0, dep_flag=0.
  - `btn_q` resets to 1, so a button held through reset does not ignite.
- Ignition latency:
  - Button edge seen at clock edge n: state=IGNITE after edge n.
  - blade_len=k after edge n+k.
  - state=ON after edge n+IGNITE_STEPS.
- Retraction from length L takes L cycles. Retract from length 0 goes to OFF/DEPLETED on the next edge.
- Config/color requests: `cfg_ack`, `color_load` and `config_set` update on the edge that samples the request. Pulses last exactly one cycle; a held request re-acks every cycle.
- Clash: CLASH lasts exactly CLASH_CYCLES cycles unless reloaded or preempted.
- `rst` mid-operation returns all outputs to reset values on the next edge, regardless of state.

## Structure
- Package `saber_pkg`:
  - State encodings.
  - power_use codes: USE_NONE, USE_IDLE, USE_IGNITE, USE_CLASH.
  - power_mode constants: MODE_DRAIN, MODE_CHARGE.
- Sub-module `rise_detect`: registered rising-edge detector with a parameterised reset value, used for `pwr_btn`.
- Everything else stays in one FSM module.

## Test plan
- Reset with `pwr_btn` held at 1 → state stays OFF. Release, then press with power_level=200 → blade_len counts 1..8 over 8 cycles, then state=ON, power_use=1, saber_on=1.
- In ON, pulse `clash` for 1 cycle → power_use=3 for exactly 4 cycles, then back to 1. A second clash at cycle 2 extends CLASH to 6 cycles total.
- In ON, assert `cfg_req` with `cfg_in`=3 and `color_req` together → config_set=3, and cfg_ack and color_load each high for exactly one cycle.
- Press the button at blade_len=5 during IGNITE → RETRACT. blade_len counts 4..0, then OFF with power_mode=1.
- In ON, drop power_level to 16 → RETRACT, then DEPLETED. Button presses are ignored. Raise power_level to 31 → stays DEPLETED; at 32 → OFF.
- Assert `rst` in CLASH with blade_len=8 → on the next edge all outputs equal their reset values.
